// File: rtl/seq_add_ctrl_pkg.sv
// Shared definitions for the slice-serial adder: FSM state encoding and slice width.
package seq_add_ctrl_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

endpackage

// File: rtl/seq_add_ctrl_cskip_slice8.sv
// Combinational 8-bit carry-skip adder: two 4-bit ripple groups, each with a
// skip mux that forwards the group carry-in when every bit propagates.
module cskip_slice8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       c_msb
);

    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Ripple inside each group; the group carry-out is replaced by the group
    // carry-in when the whole group propagates (the skip path).
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int grp = 0; grp < 2; grp++) begin
            for (int i = 0; i < 4; i++) begin
                s[4*grp+i]   = p[4*grp+i] ^ c[4*grp+i];
                c[4*grp+i+1] = g[4*grp+i] | (p[4*grp+i] & c[4*grp+i]);
            end
            if (&p[4*grp +: 4]) begin
                c[4*grp+4] = c[4*grp];
            end
        end
    end

    assign cout  = c[8];
    assign c_msb = c[7];

endmodule

// File: rtl/seq_add_ctrl.sv
// Slice-serial W-bit adder: one shared carry-skip slice adds 8 bits per cycle,
// with a valid/ready handshake on both the operand and the result side.
module seq_add_ctrl
    import seq_add_ctrl_pkg::*;
#(
    parameter int N_SLICES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICE_W*N_SLICES-1:0] a,
    input  logic [SLICE_W*N_SLICES-1:0] b,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICE_W*N_SLICES-1:0] sum,
    output logic                        cout,
    output logic                        ovf,
    output logic                        busy
);

    localparam int W  = SLICE_W * N_SLICES;
    localparam int CW = 3;
    localparam logic [CW-1:0] LAST = CW'(N_SLICES - 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry;
    logic          ovf_reg;
    logic          accept;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_cout;
    logic               sl_cmsb;

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < N_SLICES; i++) begin
            if (cnt == CW'(i)) begin
                sl_a = a_reg[i*SLICE_W +: SLICE_W];
                sl_b = b_reg[i*SLICE_W +: SLICE_W];
            end
        end
    end

    cskip_slice8 u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (carry),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // in_ready is low in DONE, so the return to IDLE never doubles as an accept.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            a_reg   <= a;
            b_reg   <= b;
            sum_reg <= '0;
            carry   <= cin;
            ovf_reg <= 1'b0;
        end else if (state == RUN) begin
            for (int i = 0; i < N_SLICES; i++) begin
                if (cnt == CW'(i)) begin
                    sum_reg[i*SLICE_W +: SLICE_W] <= sl_s;
                end
            end
            carry <= sl_cout;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
                ovf_reg <= sl_cmsb ^ sl_cout;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = carry;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Self-checking bench for seq_add_ctrl: directed corner cases plus a randomized
// handshake regression scored against an arithmetic reference model.
module tb_seq_add_ctrl;

    localparam int N    = 4;
    localparam int W    = 8 * N;
    localparam int NOPS = 4000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    seq_add_ctrl #(.N_SLICES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {v, t};
    endfunction

    // Presents one operand set, then waits (bounded) for out_valid.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            output int lat, output bit timed_out);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        timed_out = !out_valid;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h expected rdy=1 others 0",
                     in_ready, out_valid, busy, cout, ovf, sum);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic [W+1:0] spec_exp);
        int lat;
        bit to;
        start_op(x, y, c, lat, to);
        checks++;
        if (to || lat != N) begin
            failures++;
            $display("[TB] FAIL %s_latency: got %0d (timeout=%0d) expected %0d", name, lat, to, N);
        end
        checks++;
        if ({ovf, cout, sum} !== spec_exp) begin
            failures++;
            $display("[TB] FAIL %s_result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                     name, ovf, cout, sum, spec_exp[W+1], spec_exp[W], spec_exp[W-1:0]);
        end
        take_result();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL %s_return_idle: got rdy=%b vld=%b busy=%b expected 1 0 0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        logic [W-1:0] x, y;
        logic [W-1:0] s0;
        logic [W+1:0] exp_r;
        x = $urandom; y = $urandom;
        exp_r = model(x, y, 1'b1);
        start_op(x, y, 1'b1, lat, to);
        s0 = exp_r[W-1:0];
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, s0}) begin
                failures++;
                $display("[TB] FAIL backpressure_hold%0d: got vld=%b rdy=%b sum=%h expected vld=1 rdy=0 sum=%h",
                         i, out_valid, in_ready, sum, s0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL backpressure_release: got vld=%b rdy=%b busy=%b expected 0 1 0",
                     out_valid, in_ready, busy);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit to;
        bit saw_valid;
        a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL midop_reset_outputs: got rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h expected rdy=1 others 0",
                     in_ready, out_valid, busy, cout, ovf, sum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            failures++;
            $display("[TB] FAIL midop_no_result: got out_valid=1 expected 0");
        end
        start_op(32'h5, 32'h3, 1'b0, lat, to);
        checks++;
        if (to || sum !== 32'h8) begin
            failures++;
            $display("[TB] FAIL midop_next_op: got sum=%h timeout=%0d expected 00000008", sum, to);
        end
        take_result();
    endtask

    task automatic test_random();
        logic [W+1:0] q[$];
        logic [W+1:0] exp_r;
        int accepts;
        int results;
        int cyc;
        accepts = 0; results = 0; cyc = 0;
        while (accepts < NOPS && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = $urandom;
            b         = $urandom;
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin));
                accepts++;
            end
            if (out_valid && out_ready) begin
                results++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL random_spurious: got result %h with no accepted operands", sum);
                end else begin
                    exp_r = q.pop_front();
                    if ({ovf, cout, sum} !== exp_r) begin
                        failures++;
                        $display("[TB] FAIL random_result%0d: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                                 results, ovf, cout, sum, exp_r[W+1], exp_r[W], exp_r[W-1:0]);
                    end
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            #3;
            if (out_valid) begin
                results++;
                exp_r = q.pop_front();
                checks++;
                if ({ovf, cout, sum} !== exp_r) begin
                    failures++;
                    $display("[TB] FAIL random_drain: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                             ovf, cout, sum, exp_r[W+1], exp_r[W], exp_r[W-1:0]);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (accepts != NOPS || results != accepts) begin
            failures++;
            $display("[TB] FAIL random_count: got results=%0d accepts=%0d expected both %0d",
                     results, accepts, NOPS);
        end
    endtask

    initial begin
        test_reset();
        test_directed("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        test_directed("skip_path",   32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, {1'b0, 1'b1, 32'h0000_0000});
        test_directed("overflow",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        test_directed("neg_ovf",     32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 32'h0000_0000});
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
